// File: rtl/pwm_gate_driver.sv
// Half-bridge gate driver: dead-time insertion, minimum pulse widths and a latched overcurrent fault.
// Optional bootstrap precharge on enable, selected by defining BOOTSTRAP_PRECHARGE_EN.
module pwm_gate_driver #(
    parameter int DEAD_CYCLES      = 20,
    parameter int MIN_PULSE        = 10,
    parameter int FAULT_HOLD       = 2000,
    parameter int PRECHARGE_CYCLES = 4000
) (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    input  logic en_in,
    input  logic ocp,
    input  logic fault_clr,
    output logic gate_h,
    output logic gate_l,
    output logic fault,
    output logic active
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_LOW       = 3'd1,
        ST_DEAD_TO_H = 3'd2,
        ST_HIGH      = 3'd3,
        ST_DEAD_TO_L = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
    localparam logic [15:0] MIN_LAST  = 16'(MIN_PULSE - 1);
    localparam logic [15:0] HOLD_LAST = 16'(FAULT_HOLD - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PRECHARGE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

`ifdef BOOTSTRAP_PRECHARGE_EN
    localparam logic PRECHARGE_ON = 1'b1;
`else
    localparam logic PRECHARGE_ON = 1'b0;
`endif

    state_t      state_r;
    state_t      next_s;
    logic [15:0] cnt_r;
    logic        restart_s;
    logic        ocp_meta_r;
    logic        ocp_sync_r;
    // Set once the high side has conducted since the low side last did; OFF must then cover the dead time.
    logic        h_used_r;
    logic        precharge_r;

    // Two-flop synchroniser for the asynchronous overcurrent comparator.
    always_ff @(posedge clock) begin
        if (reset) begin
            ocp_meta_r <= 1'b0;
            ocp_sync_r <= 1'b0;
        end else begin
            ocp_meta_r <= ocp;
            ocp_sync_r <= ocp_meta_r;
        end
    end

    // Next-state decision with priority ocp > disable > normal sequencing.
    always_comb begin
        next_s    = state_r;
        restart_s = 1'b0;
        if (ocp_sync_r) begin
            next_s = ST_FAULT;
        end else if (!en_in && (state_r != ST_FAULT)) begin
            next_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (!h_used_r || (cnt_r >= DEAD_LAST)) next_s = ST_LOW;
                    else                                    next_s = ST_OFF;
                end
                ST_LOW: begin
                    if (precharge_r) begin
                        // Precharge done: restart the counter so the minimum on-time starts afresh.
                        if (cnt_r >= PRE_LAST) restart_s = 1'b1;
                        else                   restart_s = 1'b0;
                    end else if (pwm_in && (cnt_r >= MIN_LAST)) begin
                        next_s = ST_DEAD_TO_H;
                    end else begin
                        next_s = ST_LOW;
                    end
                end
                ST_DEAD_TO_H: begin
                    if (!pwm_in)                 next_s = ST_LOW;
                    else if (cnt_r == DEAD_LAST) next_s = ST_HIGH;
                    else                         next_s = ST_DEAD_TO_H;
                end
                ST_HIGH: begin
                    if (!pwm_in && (cnt_r >= MIN_LAST)) next_s = ST_DEAD_TO_L;
                    else                                next_s = ST_HIGH;
                end
                ST_DEAD_TO_L: begin
                    if (pwm_in)                  next_s = ST_HIGH;
                    else if (cnt_r == DEAD_LAST) next_s = ST_LOW;
                    else                         next_s = ST_DEAD_TO_L;
                end
                ST_FAULT: begin
                    if (fault_clr && (cnt_r >= HOLD_LAST)) next_s = ST_OFF;
                    else                                   next_s = ST_FAULT;
                end
                default: next_s = ST_OFF;
            endcase
        end
    end

    // State, counter and outputs all registered on the same edge, outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_OFF;
            cnt_r       <= 16'd0;
            h_used_r    <= 1'b0;
            precharge_r <= 1'b0;
            gate_h      <= 1'b0;
            gate_l      <= 1'b0;
            fault       <= 1'b0;
            active      <= 1'b0;
        end else begin
            state_r <= next_s;
            if ((next_s != state_r) || restart_s) cnt_r <= 16'd0;
            else if (cnt_r != CNT_MAX)            cnt_r <= cnt_r + 16'd1;
            else                                  cnt_r <= cnt_r;

            if (next_s == ST_HIGH)     h_used_r <= 1'b1;
            else if (next_s == ST_LOW) h_used_r <= 1'b0;
            else                       h_used_r <= h_used_r;

            if (PRECHARGE_ON && (state_r == ST_OFF) && (next_s == ST_LOW)) precharge_r <= 1'b1;
            else if ((next_s != ST_LOW) || restart_s)                      precharge_r <= 1'b0;
            else                                                           precharge_r <= precharge_r;

            gate_h <= (next_s == ST_HIGH);
            gate_l <= (next_s == ST_LOW);
            fault  <= (next_s == ST_FAULT);
            active <= (next_s == ST_LOW) || (next_s == ST_DEAD_TO_H) ||
                      (next_s == ST_HIGH) || (next_s == ST_DEAD_TO_L);
        end
    end

endmodule

// File: tb/tb_pwm_gate_driver.sv
// Bench for pwm_gate_driver: directed timing pins plus randomized traffic against a timestamp-based model.
module tb_pwm_gate_driver;
    localparam int DEAD  = 4;
    localparam int MINP  = 8;
    localparam int FHOLD = 16;
    localparam int PRE   = 50;

    logic clock = 1'b0;
    logic reset, pwm_in, en_in, ocp, fault_clr;
    logic gate_h, gate_l, fault, active;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: which side conducts (0 none, 1 low, 2 high), side being approached during a gap,
    // fault latch, and the absolute cycle of the last phase change.
    int cyc = 0;
    int t_mark = 0;
    int dwell;
    int m_on = 0;
    int m_want = 0;
    bit m_fault = 1'b0;
    bit m_hi = 1'b0;
    bit m_pre = 1'b0;
    bit o1 = 1'b0, o2 = 1'b0, os;
    int hold = 0;

    pwm_gate_driver #(
        .DEAD_CYCLES(DEAD), .MIN_PULSE(MINP), .FAULT_HOLD(FHOLD), .PRECHARGE_CYCLES(PRE)
    ) dut (
        .clock(clock), .reset(reset), .pwm_in(pwm_in), .en_in(en_in), .ocp(ocp),
        .fault_clr(fault_clr), .gate_h(gate_h), .gate_l(gate_l), .fault(fault), .active(active)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference behaviour evaluated on every rising edge from the inputs held stable since the last falling edge.
    always @(posedge clock) begin
        cyc++;
        os = o2;
        o2 = o1;
        o1 = ocp;
        dwell = cyc - t_mark;
        if (reset) begin
            m_fault = 0; m_on = 0; m_want = 0; m_hi = 0; m_pre = 0;
            o1 = 0; o2 = 0; t_mark = cyc;
        end else if (os) begin
            if (!m_fault) begin
                m_fault = 1; m_on = 0; m_want = 0; m_pre = 0; t_mark = cyc;
            end
        end else if (m_fault) begin
            if (fault_clr && dwell >= FHOLD) begin
                m_fault = 0; t_mark = cyc;
            end
        end else if (!en_in) begin
            if (m_on != 0 || m_want != 0) begin
                m_on = 0; m_want = 0; m_pre = 0; t_mark = cyc;
            end
        end else if (m_on == 0 && m_want == 0) begin
            if (!m_hi || dwell >= DEAD) begin
                m_on = 1; m_hi = 0; t_mark = cyc;
`ifdef BOOTSTRAP_PRECHARGE_EN
                m_pre = 1;
`endif
            end
        end else if (m_on == 1) begin
            if (m_pre) begin
                if (dwell >= PRE) begin
                    m_pre = 0; t_mark = cyc;
                end
            end else if (pwm_in && dwell >= MINP) begin
                m_on = 0; m_want = 2; t_mark = cyc;
            end
        end else if (m_on == 2) begin
            if (!pwm_in && dwell >= MINP) begin
                m_on = 0; m_want = 1; t_mark = cyc;
            end
        end else if (m_want == 2) begin
            if (!pwm_in) begin
                m_on = 1; m_want = 0; m_hi = 0; t_mark = cyc;
            end else if (dwell >= DEAD) begin
                m_on = 2; m_want = 0; m_hi = 1; t_mark = cyc;
            end
        end else begin
            if (pwm_in) begin
                m_on = 2; m_want = 0; m_hi = 1; t_mark = cyc;
            end else if (dwell >= DEAD) begin
                m_on = 1; m_want = 0; m_hi = 0; t_mark = cyc;
            end
        end
    end

    // Every-cycle comparison against the model, plus the shoot-through invariant.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_gate_h", gate_h, m_on == 2);
            chk("model_gate_l", gate_l, m_on == 1);
            chk("model_fault", fault, m_fault);
            chk("model_active", active, !m_fault && (m_on != 0 || m_want != 0));
            chk("no_shoot_through", gate_h & gate_l, 1'b0);
        end
    end

    initial begin
        reset = 1'b1; en_in = 1'b0; pwm_in = 1'b0; ocp = 1'b0; fault_clr = 1'b0;
        step(2);
        chk_en = 1'b1;
        chk("reset_gate_h", gate_h, 1'b0);
        chk("reset_gate_l", gate_l, 1'b0);
        chk("reset_fault", fault, 1'b0);
        chk("reset_active", active, 1'b0);

`ifndef BOOTSTRAP_PRECHARGE_EN
        // Dead time: LOW for MINP clocks, then gate_l drops and gate_h follows DEAD edges later.
        reset = 1'b0; en_in = 1'b1; pwm_in = 1'b1;
        step(1); chk("t1_low_entry", gate_l, 1'b1);
        step(7); chk("t1_low_held", gate_l, 1'b1);
        step(1); chk("t1_l_released", gate_l, 1'b0);
        step(3); chk("t1_h_not_yet", gate_h, 1'b0);
        step(1); chk("t1_h_on", gate_h, 1'b1);
        // Minimum pulse in HIGH.
        pwm_in = 1'b0;
        step(7); chk("t2_h_min_held", gate_h, 1'b1);
        step(1); chk("t2_h_released", gate_h, 1'b0);
        step(4); chk("t2_l_on", gate_l, 1'b1);
        // Dead-time abort.
        step(7); pwm_in = 1'b1;
        step(1); chk("t3_in_dead", gate_l, 1'b0);
        step(2); pwm_in = 1'b0;
        step(1); chk("t3_abort_low", gate_l, 1'b1);
        chk("t3_abort_no_h", gate_h, 1'b0);
        // Short pulse in LOW ignored.
        step(1); pwm_in = 1'b1;
        step(3); pwm_in = 1'b0;
        step(2); chk("t2_short_ignored", gate_l, 1'b1);
        // Overcurrent fault, early clear ignored, later clear accepted.
        pwm_in = 1'b1;
        step(7); chk("t4_high", gate_h, 1'b1);
        ocp = 1'b1;
        step(1); ocp = 1'b0;
        step(2); chk("t4_fault", fault, 1'b1);
        chk("t4_gates_off", gate_h, 1'b0);
        step(4); fault_clr = 1'b1;
        step(1); fault_clr = 1'b0;
        step(1); chk("t4_early_clr", fault, 1'b1);
        step(13); fault_clr = 1'b1;
        step(1); fault_clr = 1'b0;
        chk("t4_cleared", fault, 1'b0);
        step(3); chk("t4_off_dead_wait", gate_l, 1'b0);
        step(1); chk("t4_low_after_off", gate_l, 1'b1);
        // Disable mid-HIGH, then reset during DEAD_TO_L.
        step(13); chk("t5_high", gate_h, 1'b1);
        en_in = 1'b0;
        step(1); chk("t5_dis_gate_h", gate_h, 1'b0);
        chk("t5_dis_active", active, 1'b0);
        en_in = 1'b1;
        step(16); chk("t5_high_again", gate_h, 1'b1);
        pwm_in = 1'b0;
        step(9); chk("t5_dead_to_l", active, 1'b1);
        reset = 1'b1;
        step(1); chk("t5_rst_gate_h", gate_h, 1'b0);
        chk("t5_rst_gate_l", gate_l, 1'b0);
        chk("t5_rst_active", active, 1'b0);
        reset = 1'b0;
        step(1); chk("t5_low_no_wait", gate_l, 1'b1);
`endif

        // Randomized traffic checked by the model every cycle.
        reset = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                pwm_in = ~pwm_in;
                hold = $urandom_range(1, 24);
            end else begin
                hold--;
            end
            en_in     = ($urandom_range(0, 150) != 0);
            ocp       = ($urandom_range(0, 400) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            step(1);
        end
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pwm_gate_driver.md
Name: pwm_gate_driver

Overview:
- Downstream stage of the PWM generator: consumes its single-ended pwm/en pair and drives a half-bridge as complementary high-side/low-side gates.
- Inserts programmable dead time and enforces minimum on/off times.
- Latches an overcurrent fault that forces both gates off until explicitly cleared.
- Runs on the same 200 MHz PWM clock domain.

Parameters:
- DEAD_CYCLES, 20: clocks with both gates low between any gate handover; legal range 1..65535.
- MIN_PULSE, 10: minimum clocks spent in HIGH or LOW before a new edge of pwm_in is acted on; legal range 1..65535.
- FAULT_HOLD, 2000: minimum clocks spent in FAULT before a clear is accepted; legal range 1..65535.
- PRECHARGE_CYCLES, 4000: bootstrap precharge length; used only with the optional feature.

Ports:
- clock  in  1  200 MHz PWM clock.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  raw PWM from the generator, synchronous to clock.
- en_in  in  1  bridge enable from the generator.
- ocp  in  1  asynchronous overcurrent comparator, active-high.
- fault_clr  in  1  single-cycle fault acknowledge.
- gate_h  out  1  high-side gate command.
- gate_l  out  1  low-side gate command.
- fault  out  1  high while in FAULT.
- active  out  1  high in LOW, DEAD_TO_H, HIGH and DEAD_TO_L.

Behaviour:
- Single clock; reset is synchronous and active-high.
- All outputs are registered and updated on the same edge as the state register.
- Reset values: gate_h=0, gate_l=0, fault=0, active=0, state=OFF, counters=0, ocp synchroniser flops=0.
- ocp passes through a 2-flop synchroniser; ocp_s is the second flop output.
- States: OFF, LOW, DEAD_TO_H, HIGH, DEAD_TO_L, FAULT.
- Single 16-bit counter cnt, cleared on every state entry, incrementing each clock, saturating at 65535.
- Priority each edge: reset > ocp_s > en_in=0 > normal transitions.
- ocp_s=1 in any state → FAULT; gate_h=gate_l=0 from that edge.
- en_in=0 in any non-FAULT state → OFF; both gates 0.
- OFF → LOW when en_in=1.
- LOW:
  - gate_l=1.
  - → DEAD_TO_H when pwm_in=1 and cnt>=MIN_PULSE-1; otherwise stay.
  - pwm_in pulses shorter than the remaining minimum time are ignored.
- DEAD_TO_H:
  - Both gates 0.
  - pwm_in=0 → abort back to LOW.
  - Otherwise → HIGH when cnt==DEAD_CYCLES-1.
- HIGH:
  - gate_h=1.
  - → DEAD_TO_L when pwm_in=0 and cnt>=MIN_PULSE-1.
- DEAD_TO_L:
  - Both gates 0.
  - pwm_in=1 → abort back to HIGH.
  - Otherwise → LOW when cnt==DEAD_CYCLES-1.
- Latency: pwm_in rising, sampled at edge N in LOW with the minimum satisfied, gives gate_l=0 after edge N and gate_h=1 after edge N+DEAD_CYCLES. Falling edge is symmetric.
- FAULT:
  - fault=1, both gates 0.
  - → OFF only when fault_clr=1, ocp_s=0 and cnt>=FAULT_HOLD-1.
  - fault_clr arriving earlier is discarded, not remembered.
  - ocp_s re-asserting while in FAULT does not restart cnt.
- Invariant, every cycle: gate_h & gate_l == 0.
- Every transition between gate_h=1 and gate_l=1 passes through at least DEAD_CYCLES clocks with both gates low, including transitions via OFF.
- Reset asserted mid-operation: both gates 0 after that edge; state OFF; no dead-time wait is required after reset.

Optional Feature:
- Macro: BOOTSTRAP_PRECHARGE_EN.
- Defined:
  - OFF → LOW entry holds gate_l=1 for PRECHARGE_CYCLES clocks, ignoring pwm_in, before the MIN_PULSE check starts.
  - active=1 during precharge.
  - ocp_s and en_in=0 still preempt precharge.
- Undefined:
  - LOW behaves as above from the first cycle.
  - The PRECHARGE_CYCLES parameter is unused.

Test Plan:
1. Dead time (DEAD_CYCLES=4, MIN_PULSE=8, en_in=1): after reset, LOW for 8 clocks, then pwm_in=1 → gate_l falls next edge; gate_h rises exactly 4 edges later; gate_h&gate_l never 1.
2. Minimum pulse: in LOW, 3-clock pwm_in=1 pulse starting 2 clocks after LOW entry → ignored, gate_l stays 1. In HIGH, pwm_in=0 at HIGH cycle 1 → gate_h held 8 clocks, then handover.
3. Dead-time abort: in DEAD_TO_H, pwm_in returns to 0 at cnt=2 → LOW next edge with gate_l=1; gate_h never asserted.
4. Fault (FAULT_HOLD=16): ocp pulse high 1 clock while in HIGH → both gates 0 within 3 edges, fault=1. fault_clr at cycle 5 → ignored. fault_clr at cycle 20 with ocp low → OFF, then LOW.
5. en_in=0 mid-HIGH → both gates 0 next edge. Reset asserted during DEAD_TO_L → all outputs 0, state OFF.
6. With BOOTSTRAP_PRECHARGE_EN defined and PRECHARGE_CYCLES=50: enable with pwm_in=1 → gate_l=1 for 50 clocks, plus MIN_PULSE, before the dead-time sequence starts.
